// File: rtl/rnn_step_sequencer_if.sv
// Frame, datapath and result bundle for rnn_step_sequencer.
// The master side feeds frames, returns dp_y and consumes the result; the slave side is the sequencer.
interface rnn_step_sequencer_if #(
    parameter int WIDTH       = 17,
    parameter int INPUT_SIZE  = 4,
    parameter int HIDDEN_SIZE = 8
);
    logic                                         in_valid;
    logic                                         in_ready;
    logic [INPUT_SIZE-1:0][WIDTH-1:0]             in_data;
    logic [INPUT_SIZE+HIDDEN_SIZE-1:0][WIDTH-1:0] dp_x;
    logic [HIDDEN_SIZE-1:0][WIDTH-1:0]            dp_y;
    logic                                         out_valid;
    logic                                         out_ready;
    logic [HIDDEN_SIZE-1:0][WIDTH-1:0]            out_data;

    modport master (
        output in_valid, in_data, dp_y, out_ready,
        input  in_ready, dp_x, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, dp_y, out_ready,
        output in_ready, dp_x, out_valid, out_data
    );
endinterface

// File: rtl/rnn_step_sequencer.sv
// Steps a fixed-latency recurrent datapath over SEQ_LEN frames, feeding back the hidden state,
// and presents the final hidden state over valid/ready.
module rnn_step_sequencer #(
    parameter int WIDTH       = 17,
    parameter int INPUT_SIZE  = 4,
    parameter int HIDDEN_SIZE = 8,
    parameter int SEQ_LEN     = 16,
    parameter int DP_LATENCY  = 6,
    localparam int STEP_W     = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
    localparam int WAIT_W     = $clog2(DP_LATENCY + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              abort,
    rnn_step_sequencer_if.slave bus,
    output logic [STEP_W-1:0] step_idx,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SEQ_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(DP_LATENCY);

    state_t                            state_q, state_d;
    logic [INPUT_SIZE-1:0][WIDTH-1:0]  x_q, x_d;
    logic [HIDDEN_SIZE-1:0][WIDTH-1:0] h_q, h_d;
    logic [STEP_W-1:0]                 step_q, step_d;
    logic [WAIT_W-1:0]                 wait_q, wait_d;
    logic                              in_ready_c;
    logic                              out_valid_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            h_q     <= '0;
            step_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            h_q     <= h_d;
            step_q  <= step_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        h_d         = h_q;
        step_d      = step_q;
        wait_d      = wait_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready_c = !abort;
                if (bus.in_valid && !abort) begin
                    x_d     = bus.in_data;
                    wait_d  = WAIT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end else begin
                    h_d = bus.dp_y;
                    if (step_q == STEP_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        step_d  = step_q + STEP_W'(1);
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    h_d     = '0;
                    step_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides whatever the state decode chose, dropping any pending datapath result.
        if (abort) begin
            state_d = S_IDLE;
            h_d     = '0;
            step_d  = '0;
            wait_d  = '0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.dp_x      = {h_q, x_q};
    assign bus.out_data  = h_q;
    assign step_idx      = step_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_rnn_step_sequencer.sv
// Directed bench for rnn_step_sequencer with a y[j] = x[0] + h[j] pipelined datapath model.
module tb_rnn_step_sequencer;

    localparam int W  = 17;
    localparam int I  = 2;
    localparam int H  = 3;
    localparam int SL = 4;
    localparam int L  = 3;

    typedef logic [H-1:0][W-1:0]   hvec_t;
    typedef logic [I+H-1:0][W-1:0] xvec_t;

    logic clk = 1'b0;
    logic reset;
    logic abort;
    logic abort2;
    logic [1:0] step_idx;
    logic       busy;
    logic [0:0] step_idx2;
    logic       busy2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = 0;
    int hf;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rnn_step_sequencer_if #(.WIDTH(W), .INPUT_SIZE(I), .HIDDEN_SIZE(H)) bus ();
    rnn_step_sequencer_if #(.WIDTH(W), .INPUT_SIZE(I), .HIDDEN_SIZE(H)) bus2 ();

    rnn_step_sequencer #(
        .WIDTH(W), .INPUT_SIZE(I), .HIDDEN_SIZE(H), .SEQ_LEN(SL), .DP_LATENCY(L)
    ) dut (
        .clk(clk), .reset(reset), .abort(abort), .bus(bus.slave),
        .step_idx(step_idx), .busy(busy)
    );

    rnn_step_sequencer #(
        .WIDTH(W), .INPUT_SIZE(I), .HIDDEN_SIZE(H), .SEQ_LEN(1), .DP_LATENCY(1)
    ) dut2 (
        .clk(clk), .reset(reset), .abort(abort2), .bus(bus2.slave),
        .step_idx(step_idx2), .busy(busy2)
    );

    function automatic hvec_t dp_model(input xvec_t x);
        hvec_t r;
        for (int unsigned j = 0; j < H; j++) r[j] = x[0] + x[I+j];
        return r;
    endfunction

    function automatic hvec_t spread(input int v);
        hvec_t r;
        for (int unsigned j = 0; j < H; j++) r[j] = W'(v);
        return r;
    endfunction

    function automatic xvec_t mk_dpx(input int x0, input int x1, input int h);
        xvec_t r;
        r[0] = W'(x0);
        r[1] = W'(x1);
        for (int unsigned j = 0; j < H; j++) r[I+j] = W'(h);
        return r;
    endfunction

    // Datapath models: L and 1 register stages respectively.
    hvec_t pipe [L];
    hvec_t pipe2;
    always @(posedge clk) begin
        pipe[0] <= dp_model(bus.dp_x);
        for (int unsigned k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        pipe2 <= dp_model(bus2.dp_x);
    end
    assign bus.dp_y  = pipe[L-1];
    assign bus2.dp_y = pipe2;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int t;
        t = 0;
        while (!bus.in_ready && t < 20) begin
            step;
            t++;
        end
        chk("ready_wait", bus.in_ready, 1);
    endtask

    task automatic run_frame(input int x0, input int k, input int h_prev, input bit last, input bit gap);
        bus.in_data[0] = W'(x0);
        bus.in_data[1] = W'(-5);
        bus.in_valid   = 1'b1;
        wait_ready;
        step;
        if (gap) chk("accept_gap", cyc - last_acc, L + 2);
        last_acc = cyc;
        chk("acc_step_idx", step_idx, k);
        chk("acc_busy", busy, 1);
        chk("acc_in_ready", bus.in_ready, 0);
        chk("acc_dp_x", bus.dp_x, mk_dpx(x0, -5, h_prev));
        for (int unsigned n = 1; n <= L; n++) begin
            step;
            chk("wait_in_ready", bus.in_ready, 0);
            chk("wait_h_hold", bus.out_data, spread(h_prev));
            chk("wait_out_valid", bus.out_valid, 0);
        end
        step;
        chk("load_h", bus.out_data, spread(h_prev + x0));
        chk("load_out_valid", bus.out_valid, last);
        chk("load_in_ready", bus.in_ready, !last);
        chk("load_step_idx", step_idx, last ? k : k + 1);
    endtask

    task automatic run_seq(input int a, input int b, input int c, input int d, output int hfin);
        int xs[4];
        int h;
        xs = '{a, b, c, d};
        h  = 0;
        for (int unsigned k = 0; k < SL; k++) begin
            run_frame(xs[k], int'(k), h, k == SL - 1, k != 0);
            h = h + xs[k];
        end
        hfin = h;
    endtask

    task automatic drain;
        bus.out_ready = 1'b1;
        step;
        bus.out_ready = 1'b0;
        chk("drain_busy", busy, 0);
        chk("drain_out_data", bus.out_data, spread(0));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout cycles=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; abort = 1'b0; abort2 = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;
        repeat (5) step;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_step_idx", step_idx, 0);
        chk("rst_dp_x", bus.dp_x, mk_dpx(0, 0, 0));
        chk("rst_out_data", bus.out_data, spread(0));
        reset = 1'b0;
        step;

        // Sequence 1: frames 1..4 back to back.
        run_seq(1, 2, 3, 4, hf);
        chk("seq1_out", bus.out_data, spread(10));

        // Backpressure in DONE.
        for (int unsigned n = 0; n < 10; n++) begin
            step;
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_out_data", bus.out_data, spread(10));
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        step;
        bus.out_ready = 1'b0;
        chk("rel_busy", busy, 0);
        chk("rel_out_valid", bus.out_valid, 0);
        chk("rel_step_idx", step_idx, 0);
        chk("rel_out_data", bus.out_data, spread(0));
        chk("rel_in_ready", bus.in_ready, 1);
        run_seq(5, 5, 5, 5, hf);
        chk("seq2_out", bus.out_data, spread(20));
        drain;

        // Abort in the WAIT of step 2.
        run_frame(3, 0, 0, 1'b0, 1'b0);
        run_frame(3, 1, 3, 1'b0, 1'b1);
        bus.in_data[0] = W'(3);
        wait_ready;
        step;
        step;
        chk("pre_abort_step", step_idx, 2);
        abort = 1'b1;
        #1;
        chk("abort_in_ready", bus.in_ready, 0);
        step;
        abort = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_step_idx", step_idx, 0);
        chk("abort_out_data", bus.out_data, spread(0));
        run_seq(1, 1, 1, 1, hf);
        chk("seq3_out", bus.out_data, spread(4));
        drain;

        // Asynchronous reset between edges mid-WAIT.
        bus.in_data[0] = W'(2);
        wait_ready;
        step;
        step;
        chk("pre_rst_busy", busy, 1);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_step_idx", step_idx, 0);
        chk("arst_dp_x", bus.dp_x, mk_dpx(0, 0, 0));
        chk("arst_out_data", bus.out_data, spread(0));
        step;
        step;
        reset = 1'b0;
        run_seq(2, 2, 2, 2, hf);
        chk("seq4_out", bus.out_data, spread(8));
        drain;
        bus.in_valid = 1'b0;

        // SEQ_LEN=1, DP_LATENCY=1 instance.
        bus2.in_data[0] = W'(7);
        bus2.in_data[1] = W'(0);
        bus2.in_valid   = 1'b1;
        #1;
        chk("s1_in_ready", bus2.in_ready, 1);
        step;
        bus2.in_valid = 1'b0;
        chk("s1_acc_busy", busy2, 1);
        chk("s1_acc_out_valid", bus2.out_valid, 0);
        step;
        chk("s1_wait_out_valid", bus2.out_valid, 0);
        step;
        chk("s1_out_valid", bus2.out_valid, 1);
        chk("s1_out_data", bus2.out_data, spread(7));
        chk("s1_step_idx", step_idx2, 0);
        bus2.out_ready = 1'b1;
        step;
        bus2.out_ready = 1'b0;
        chk("s1_rel_busy", busy2, 0);
        chk("s1_rel_out_data", bus2.out_data, spread(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rnn_step_sequencer.md
Name: rnn_step_sequencer

Overview:
- Sequences a fixed-latency, non-handshaked dense/GRU datapath across the timesteps of one input sequence.
- Per step:
  - accepts one input frame over valid/ready;
  - drives the datapath with {frame, previous hidden state};
  - waits out the datapath latency;
  - captures the result as the new hidden state.
- After SEQ_LEN steps it presents the final hidden state over valid/ready.
- Sits between the feature stream and the recurrent dense layer of the RNN.

Parameters:
- WIDTH, 17, bit width of every signed fixed-point element.
- INPUT_SIZE, 4, elements per input frame.
- HIDDEN_SIZE, 8, elements in the hidden state and in the datapath output.
- SEQ_LEN, 16, timesteps per sequence; must be >= 1.
- DP_LATENCY, 6, rising edges from a datapath input change until dp_y reflects it; must be >= 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- abort  in  1  synchronous sequence abort.
- in_valid  in  1  input frame valid.
- in_ready  out  1  sequencer can accept a frame.
- in_data  in  WIDTH x INPUT_SIZE  signed input frame.
- dp_x  out  WIDTH x (INPUT_SIZE+HIDDEN_SIZE)  datapath input; indices 0..INPUT_SIZE-1 = frame, INPUT_SIZE.. = hidden state.
- dp_y  in  WIDTH x HIDDEN_SIZE  datapath output.
- out_valid  out  1  final hidden state valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH x HIDDEN_SIZE  final hidden state.
- step_idx  out  max(1,$clog2(SEQ_LEN))  index of the current step.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Registers: state, x_reg[INPUT_SIZE], h_reg[HIDDEN_SIZE], step_idx, wait_cnt (width $clog2(DP_LATENCY+1)).
- Reset (async, active-high) forces:
  - state=IDLE;
  - x_reg=0, h_reg=0, step_idx=0, wait_cnt=0;
  - out_valid=0, busy=0, in_ready=1, dp_x all 0, out_data all 0.
  - Handshakes have no effect while reset is asserted.
- dp_x is combinational from {x_reg, h_reg}.
  - It is stable for the whole WAIT state.
  - out_data = h_reg at all times.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready: x_reg<=in_data, wait_cnt<=DP_LATENCY, go to WAIT.
  - WAIT: in_ready=0.
    - If wait_cnt!=0: wait_cnt decrements by 1.
    - If wait_cnt==0: h_reg<=dp_y.
      - If step_idx==SEQ_LEN-1, go to DONE (step_idx held).
      - Otherwise step_idx increments and state returns to IDLE.
  - DONE: out_valid=1, in_ready=0, out_data held stable. On out_ready: h_reg<=0, step_idx<=0, go to IDLE.
- Timing:
  - h_reg loads on the (DP_LATENCY+1)-th rising edge after the accept edge.
  - With in_valid held high, frames are accepted every DP_LATENCY+2 cycles.
  - out_valid rises on the same edge that loads the final h_reg.
- First step of every sequence uses h=0; there is no other initial-state source.
- abort (sync) has priority over all transitions:
  - next state=IDLE, h_reg=0, step_idx=0, wait_cnt=0;
  - any in-flight datapath result is discarded;
  - in_ready=0 in the cycle abort is high, so no frame is accepted that cycle.
- out_valid&&!out_ready: result held indefinitely, no new frame accepted (no overwrite).
- SEQ_LEN=1: every accepted frame goes IDLE->WAIT->DONE.
- DP_LATENCY=1: WAIT lasts exactly 2 cycles.
- No arithmetic on data; values are passed through unmodified (no truncation or saturation).
- Counters never wrap: step_idx is bounded by SEQ_LEN-1; wait_cnt stops at 0.

Test Plan:
Bench datapath model: DP_LATENCY register stages computing y[j]=x[0]+h[j]. Config: SEQ_LEN=4, DP_LATENCY=3, INPUT_SIZE=2, HIDDEN_SIZE=3.
1. Frames x[0]=1,2,3,4 with in_valid always high -> accepts 5 cycles apart; out_valid after the 4th step; out_data={10,10,10}; step_idx sequence 0,1,2,3.
2. Timing: accept at edge E -> h_reg changes exactly at edge E+4; in_ready low from E+1 until the cycle after E+4.
3. Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid=1 and out_data={10,10,10} stable, in_ready=0; out_ready=1 -> IDLE; next sequence of frames 5,5,5,5 yields {20,20,20}.
4. Abort asserted during WAIT of step 2 -> next cycle IDLE, step_idx=0, busy=0; the next 4 frames of 1 yield {4,4,4} (the stale datapath result is ignored).
5. Async reset asserted mid-WAIT, between edges -> outputs immediately at reset values; after release the sequence restarts from step 0 with h=0.
6. Rebuild with SEQ_LEN=1, DP_LATENCY=1; frame x[0]=7 -> out_valid 2 cycles after accept, out_data={7,7,7}.
